adxl362_spi_responder: RTL and testbench

SPI mode-0 responder that emulates the ADXL362 register interface. It is the far end of the accelerometer SPI link and answers the project's SPI master, so the accelerometer controller can be exercised in simulation and board loop-back without a sensor. It serves register read and write commands from a small register file fed by `x_in`/`y_in` samples. Every SPI pin is oversampled in the `clk` domain.

---
 rtl/adxl362_pkg.sv | 35 +++
 rtl/adxl362_spi_checker.sv | 44 ++++
 rtl/adxl362_spi_slave_shifter.sv | 132 +++++++++++++
 rtl/adxl362_spi_responder.sv | 192 +++++++++++++++++++
 tb/tb_adxl362_spi_responder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/adxl362_pkg.sv
// Shared constants and types for the ADXL362 SPI register protocol.
// Used by both the responder model and the master-side controller.
`timescale 1ns/1ps
package adxl362_pkg;

  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h0A;

  localparam logic [7:0] ADDR_DEVID     = 8'h00;
  localparam logic [7:0] ADDR_STATUS    = 8'h0B;
  localparam logic [7:0] ADDR_XDATA_L   = 8'h0E;
  localparam logic [7:0] ADDR_XDATA_H   = 8'h0F;
  localparam logic [7:0] ADDR_YDATA_L   = 8'h10;
  localparam logic [7:0] ADDR_YDATA_H   = 8'h11;
  localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } spi_state_e;

  typedef enum logic [1:0] {
    MODE_DROP  = 2'd0,
    MODE_READ  = 2'd1,
    MODE_WRITE = 2'd2
  } spi_mode_e;

  // High data byte of a 12-bit sample, sign-extended to 8 bits.
  function automatic logic [7:0] sample_hi(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

endpackage

// File: rtl/adxl362_spi_checker.sv
// Protocol checker for the responder: flags an sclk that runs faster than
// the oversampling front end can follow.
`timescale 1ns/1ps
module adxl362_spi_checker #(
  parameter int CLK_PER_SCLK_MIN = 8
) (
  input logic clk,
  input logic reset,
  input logic sclk_rise,
  input logic active
);

  localparam logic [7:0] GAP_MIN = 8'(CLK_PER_SCLK_MIN - 1);

  logic [7:0] gap_q, gap_d;
  logic       seen_q, seen_d;

  // Cycles since the last synchronized sclk rise, saturating.
  always_comb begin
    seen_d = active & (seen_q | sclk_rise);
    if (sclk_rise) begin
      gap_d = 8'd0;
    end else if (gap_q == 8'hFF) begin
      gap_d = gap_q;
    end else begin
      gap_d = gap_q + 8'd1;
    end
  end

  // Gap counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_q  <= 8'd0;
      seen_q <= 1'b0;
    end else begin
      gap_q  <= gap_d;
      seen_q <= seen_d;
    end
  end

  sclk_period_min: assert property (@(posedge clk) disable iff (!reset)
    (sclk_rise && active && seen_q) |-> (gap_q >= GAP_MIN));

endmodule

// File: rtl/adxl362_spi_slave_shifter.sv
// Oversampled SPI mode-0 front end: pin synchronizers, registered edge
// detect, bit counter and the 8-bit receive/transmit shift registers.
`timescale 1ns/1ps
module spi_slave_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic [7:0] byte_rx,
  output logic       byte_strobe,
  output logic       ss_fall,
  output logic       ss_rise,
  output logic       sclk_rise,
  output logic       tx_req,
  output logic       active,
  output logic       miso
);

  logic [1:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] ss_sync_q, ss_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       ss_prev_q, ss_prev_d;
  logic       sclk_rise_q, sclk_rise_d;
  logic       sclk_fall_q, sclk_fall_d;
  logic       ss_fall_q, ss_fall_d;
  logic       ss_rise_q, ss_rise_d;
  logic       active_q, active_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       miso_q, miso_d;

  // Synchronizers, edge detect, bit counting and shifting.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], sclk};
    ss_sync_d   = {ss_sync_q[0], ss};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    sclk_prev_d = sclk_sync_q[1];
    ss_prev_d   = ss_sync_q[1];
    sclk_rise_d = sclk_sync_q[1] & ~sclk_prev_q;
    sclk_fall_d = ~sclk_sync_q[1] & sclk_prev_q;
    // Sync and prev both reset low, so a select already low at reset
    // release produces no fall: a frame cut by reset stays ignored.
    ss_fall_d   = ~ss_sync_q[1] & ss_prev_q;
    ss_rise_d   = ss_sync_q[1] & ~ss_prev_q & active_q;

    if (ss_fall_d) begin
      active_d = 1'b1;
    end else if (ss_sync_q[1] & ~ss_prev_q) begin
      active_d = 1'b0;
    end else begin
      active_d = active_q;
    end

    if (ss_fall_q) begin
      bit_cnt_d = 3'd0;
      rx_sh_d   = 7'd0;
    end else if (sclk_rise_q & active_q) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_sh_d   = {rx_sh_q[5:0], mosi_sync_q[1]};
    end else begin
      bit_cnt_d = bit_cnt_q;
      rx_sh_d   = rx_sh_q;
    end

    // miso is cleared together with active so it is never 1 while undriven.
    if (!active_d || ss_fall_d) begin
      miso_d  = 1'b0;
      tx_sh_d = 8'd0;
    end else if (sclk_fall_q) begin
      if (tx_load) begin
        miso_d  = tx_byte[7];
        tx_sh_d = {tx_byte[6:0], 1'b0};
      end else begin
        miso_d  = tx_sh_q[7];
        tx_sh_d = {tx_sh_q[6:0], 1'b0};
      end
    end else begin
      miso_d  = miso_q;
      tx_sh_d = tx_sh_q;
    end
  end

  // Front-end registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_sync_q <= 2'b00;
      ss_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      active_q    <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 7'd0;
      tx_sh_q     <= 8'd0;
      miso_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      sclk_rise_q <= sclk_rise_d;
      sclk_fall_q <= sclk_fall_d;
      ss_fall_q   <= ss_fall_d;
      ss_rise_q   <= ss_rise_d;
      active_q    <= active_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      miso_q      <= miso_d;
    end
  end

  assign byte_rx     = {rx_sh_q, mosi_sync_q[1]};
  assign byte_strobe = sclk_rise_q & active_q & (bit_cnt_q == 3'd7);
  assign tx_req      = sclk_fall_q & active_q & (bit_cnt_q == 3'd0);
  assign ss_fall     = ss_fall_q;
  assign ss_rise     = ss_rise_q;
  assign sclk_rise   = sclk_rise_q;
  assign active      = active_q;
  assign miso        = miso_q;

endmodule

// File: rtl/adxl362_spi_responder.sv
// ADXL362 register-interface emulator on the far end of the SPI link:
// command/address FSM, register file and per-transaction sample snapshot.
`timescale 1ns/1ps
module adxl362_spi_responder
  import adxl362_pkg::*;
#(
  parameter int         CLK_PER_SCLK_MIN = 8,
  parameter logic [7:0] DEVID            = 8'hAD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic        sample_valid,
  output logic [7:0]  power_ctl,
  output logic        reg_wr,
  output logic        txn_done
);

  logic [7:0] byte_rx;
  logic       byte_strobe, ss_fall, ss_rise, sclk_rise, tx_req, active;
  logic       tx_load;
  logic [7:0] rd_byte;

  spi_state_e  state_q, state_d;
  spi_mode_e   mode_q, mode_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  power_ctl_q, power_ctl_d;
  logic [11:0] x_hold_q, x_hold_d, y_hold_q, y_hold_d;
  logic [11:0] x_snap_q, x_snap_d, y_snap_q, y_snap_d;
  logic        data_ready_q, data_ready_d;
  logic        rd_hit_q, rd_hit_d;
  logic        reg_wr_q, reg_wr_d;

  spi_slave_shifter u_shifter (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .ss          (ss),
    .mosi        (mosi),
    .tx_load     (tx_load),
    .tx_byte     (rd_byte),
    .byte_rx     (byte_rx),
    .byte_strobe (byte_strobe),
    .ss_fall     (ss_fall),
    .ss_rise     (ss_rise),
    .sclk_rise   (sclk_rise),
    .tx_req      (tx_req),
    .active      (active),
    .miso        (miso)
  );

  adxl362_spi_checker #(
    .CLK_PER_SCLK_MIN (CLK_PER_SCLK_MIN)
  ) u_checker (
    .clk       (clk),
    .reset     (reset),
    .sclk_rise (sclk_rise),
    .active    (active)
  );

  // Register read mux; data registers come from the transaction snapshot.
  always_comb begin
    case (addr_q)
      ADDR_DEVID:     rd_byte = DEVID;
      ADDR_STATUS:    rd_byte = {7'd0, data_ready_q};
      ADDR_XDATA_L:   rd_byte = x_snap_q[7:0];
      ADDR_XDATA_H:   rd_byte = sample_hi(x_snap_q);
      ADDR_YDATA_L:   rd_byte = y_snap_q[7:0];
      ADDR_YDATA_H:   rd_byte = sample_hi(y_snap_q);
      ADDR_POWER_CTL: rd_byte = power_ctl_q;
      default:        rd_byte = 8'h00;
    endcase
  end

  assign tx_load = tx_req & (state_q == ST_DATA) & (mode_q == MODE_READ);

  // Transaction FSM, address counter, register file and sampling.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    power_ctl_d = power_ctl_q;
    x_snap_d    = x_snap_q;
    y_snap_d    = y_snap_q;
    rd_hit_d    = rd_hit_q;
    reg_wr_d    = 1'b0;

    if (sample_valid) begin
      x_hold_d = x_in;
      y_hold_d = y_in;
    end else begin
      x_hold_d = x_hold_q;
      y_hold_d = y_hold_q;
    end

    if (ss_fall) begin
      state_d  = ST_CMD;
      mode_d   = MODE_DROP;
      rd_hit_d = 1'b0;
      x_snap_d = x_hold_d;
      y_snap_d = y_hold_d;
    end else if (ss_rise) begin
      state_d = ST_IDLE;
    end else if (byte_strobe) begin
      case (state_q)
        ST_CMD: begin
          state_d = ST_ADDR;
          if (byte_rx == CMD_READ) begin
            mode_d = MODE_READ;
          end else if (byte_rx == CMD_WRITE) begin
            mode_d = MODE_WRITE;
          end else begin
            mode_d = MODE_DROP;
          end
        end
        ST_ADDR: begin
          state_d = ST_DATA;
          addr_d  = byte_rx;
        end
        ST_DATA: begin
          addr_d = addr_q + 8'd1;
          if (mode_q == MODE_WRITE) begin
            reg_wr_d = 1'b1;
            if (addr_q == ADDR_POWER_CTL) begin
              power_ctl_d = byte_rx;
            end else begin
              power_ctl_d = power_ctl_q;
            end
          end else if ((mode_q == MODE_READ) && (addr_q >= ADDR_XDATA_L) &&
                       (addr_q <= ADDR_YDATA_H)) begin
            rd_hit_d = 1'b1;
          end else begin
            rd_hit_d = rd_hit_q;
          end
        end
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end

    // A new sample beats a clear landing in the same cycle.
    if (sample_valid) begin
      data_ready_d = 1'b1;
    end else if (ss_rise && rd_hit_q) begin
      data_ready_d = 1'b0;
    end else begin
      data_ready_d = data_ready_q;
    end
  end

  // Responder state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_DROP;
      addr_q       <= 8'h00;
      power_ctl_q  <= 8'h00;
      x_hold_q     <= 12'h000;
      y_hold_q     <= 12'h000;
      x_snap_q     <= 12'h000;
      y_snap_q     <= 12'h000;
      data_ready_q <= 1'b0;
      rd_hit_q     <= 1'b0;
      reg_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      power_ctl_q  <= power_ctl_d;
      x_hold_q     <= x_hold_d;
      y_hold_q     <= y_hold_d;
      x_snap_q     <= x_snap_d;
      y_snap_q     <= y_snap_d;
      data_ready_q <= data_ready_d;
      rd_hit_q     <= rd_hit_d;
      reg_wr_q     <= reg_wr_d;
    end
  end

  assign miso_oe   = active;
  assign txn_done  = ss_rise;
  assign reg_wr    = reg_wr_q;
  assign power_ctl = power_ctl_q;

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed bench for adxl362_spi_responder: bit-banged SPI mode-0 master
// with hand-computed expected register bytes.
`timescale 1ns/1ps
module tb_adxl362_spi_responder;
  import adxl362_pkg::*;

  logic        clk = 1'b0;
  logic        reset, sclk, ss, mosi, miso, miso_oe;
  logic [11:0] x_in, y_in;
  logic        sample_valid, reg_wr, txn_done;
  logic [7:0]  power_ctl;

  logic [7:0] tx_buf [0:7];
  logic [7:0] rx_buf [0:7];

  int n_cmp = 0;
  int n_err = 0;
  int txn_cnt = 0, wr_cnt = 0, miso_hi = 0, oe_viol = 0;
  int t0, w0, m0;

  always #5 clk = ~clk;

  adxl362_spi_responder #(.CLK_PER_SCLK_MIN(8), .DEVID(8'hAD)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .x_in(x_in), .y_in(y_in),
    .sample_valid(sample_valid), .power_ctl(power_ctl), .reg_wr(reg_wr),
    .txn_done(txn_done)
  );

  always @(negedge clk) begin
    if (txn_done === 1'b1) txn_cnt <= txn_cnt + 1;
    if (reg_wr === 1'b1)   wr_cnt  <= wr_cnt + 1;
    if (miso === 1'b1)     miso_hi <= miso_hi + 1;
    if ((miso === 1'b1) && (miso_oe !== 1'b1)) oe_viol <= oe_viol + 1;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_tx(input logic [7:0] b0, b1, b2, b3, b4, b5);
    tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2;
    tx_buf[3] = b3; tx_buf[4] = b4; tx_buf[5] = b5;
  endtask

  task automatic pulse_sample(input logic [11:0] x, input logic [11:0] y);
    x_in = x; y_in = y; sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  // Mode 0: drive mosi while sclk low, master samples miso at the rise.
  task automatic spi_txn(input int nbits, input bit collide);
    ss = 1'b0;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx_buf[i / 8][7 - (i % 8)];
      tick(5);
      rx_buf[i / 8][7 - (i % 8)] = miso;
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
    end
    tick(5);
    mosi = 1'b0;
    ss = 1'b1;
    if (collide) begin
      tick(3);
      check("collide_align", {15'd0, txn_done}, 16'd1);
      pulse_sample(12'h7FF, 12'h000);
      tick(5);
    end else begin
      tick(8);
    end
  endtask

  task automatic read_status(output logic [7:0] val);
    set_tx(CMD_READ, ADDR_STATUS, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_txn(24, 1'b0);
    val = rx_buf[2];
  endtask

  logic [7:0] st;

  initial begin
    reset = 1'b0; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
    x_in = 12'h000; y_in = 12'h000; sample_valid = 1'b0;
    tick(4);
    check("rst_miso", {15'd0, miso}, 16'd0);
    check("rst_miso_oe", {15'd0, miso_oe}, 16'd0);
    check("rst_power_ctl", {8'd0, power_ctl}, 16'h0000);
    check("rst_reg_wr", {15'd0, reg_wr}, 16'd0);
    check("rst_txn_done", {15'd0, txn_done}, 16'd0);
    reset = 1'b1;
    tick(4);

    // DEVID read
    t0 = txn_cnt;
    set_tx(CMD_READ, ADDR_DEVID, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_txn(24, 1'b0);
    check("devid", {8'd0, rx_buf[2]}, 16'h00AD);
    check("devid_txn_done", 16'(txn_cnt - t0), 16'd1);

    // Burst read of one sample, STATUS before and after
    pulse_sample(12'h8A5, 12'h07F);
    read_status(st);
    check("status_before", {8'd0, st}, 16'h0001);
    set_tx(CMD_READ, ADDR_XDATA_L, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_txn(48, 1'b0);
    check("burst_xl", {8'd0, rx_buf[2]}, 16'h00A5);
    check("burst_xh", {8'd0, rx_buf[3]}, 16'h00F8);
    check("burst_yl", {8'd0, rx_buf[4]}, 16'h007F);
    check("burst_yh", {8'd0, rx_buf[5]}, 16'h0000);
    read_status(st);
    check("status_after", {8'd0, st}, 16'h0000);

    // Write POWER_CTL and read back; write to a read-only address
    w0 = wr_cnt;
    set_tx(CMD_WRITE, ADDR_POWER_CTL, 8'h02, 8'h00, 8'h00, 8'h00);
    spi_txn(24, 1'b0);
    check("wr_power_ctl", {8'd0, power_ctl}, 16'h0002);
    check("wr_reg_wr", 16'(wr_cnt - w0), 16'd1);
    set_tx(CMD_READ, ADDR_POWER_CTL, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_txn(24, 1'b0);
    check("rd_power_ctl", {8'd0, rx_buf[2]}, 16'h0002);
    w0 = wr_cnt;
    set_tx(CMD_WRITE, ADDR_XDATA_L, 8'h55, 8'h00, 8'h00, 8'h00);
    spi_txn(24, 1'b0);
    check("wr_ro_reg_wr", 16'(wr_cnt - w0), 16'd1);
    set_tx(CMD_READ, ADDR_XDATA_L, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_txn(24, 1'b0);
    check("wr_ro_xl", {8'd0, rx_buf[2]}, 16'h00A5);

    // New sample mid-burst must not disturb the running snapshot
    set_tx(CMD_READ, ADDR_XDATA_L, 8'h00, 8'h00, 8'h00, 8'h00);
    fork
      spi_txn(32, 1'b0);
      begin
        tick(200);
        pulse_sample(12'h123, 12'h07F);
      end
    join
    check("snap_old_xl", {8'd0, rx_buf[2]}, 16'h00A5);
    check("snap_old_xh", {8'd0, rx_buf[3]}, 16'h00F8);
    spi_txn(32, 1'b0);
    check("snap_new_xl", {8'd0, rx_buf[2]}, 16'h0023);
    check("snap_new_xh", {8'd0, rx_buf[3]}, 16'h0001);

    // Aborted partial bytes commit nothing and clear nothing
    pulse_sample(12'h321, 12'h000);
    w0 = wr_cnt;
    set_tx(CMD_WRITE, ADDR_POWER_CTL, 8'hF0, 8'h00, 8'h00, 8'h00);
    spi_txn(20, 1'b0);
    check("abort_power_ctl", {8'd0, power_ctl}, 16'h0002);
    check("abort_reg_wr", 16'(wr_cnt - w0), 16'd0);
    set_tx(CMD_READ, ADDR_XDATA_L, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_txn(20, 1'b0);
    read_status(st);
    check("abort_status", {8'd0, st}, 16'h0001);

    // Invalid command: silent, no writes
    m0 = miso_hi;
    set_tx(8'h55, ADDR_DEVID, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_txn(24, 1'b0);
    check("drop_miso_high", 16'(miso_hi - m0), 16'd0);
    w0 = wr_cnt;
    set_tx(8'h55, ADDR_POWER_CTL, 8'hFF, 8'h00, 8'h00, 8'h00);
    spi_txn(24, 1'b0);
    check("drop_power_ctl", {8'd0, power_ctl}, 16'h0002);
    check("drop_reg_wr", 16'(wr_cnt - w0), 16'd0);

    // Reset in the middle of a burst
    t0 = txn_cnt;
    set_tx(CMD_READ, ADDR_XDATA_L, 8'h00, 8'h00, 8'h00, 8'h00);
    fork
      spi_txn(48, 1'b0);
      begin
        tick(250);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(20);
        check("midrst_miso_oe", {15'd0, miso_oe}, 16'd0);
        check("midrst_miso", {15'd0, miso}, 16'd0);
        check("midrst_power_ctl", {8'd0, power_ctl}, 16'h0000);
      end
    join
    check("midrst_txn_done", 16'(txn_cnt - t0), 16'd0);
    read_status(st);
    check("midrst_status", {8'd0, st}, 16'h0000);
    set_tx(CMD_READ, ADDR_DEVID, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_txn(24, 1'b0);
    check("midrst_devid", {8'd0, rx_buf[2]}, 16'h00AD);

    // Sample arriving in the same cycle as the DATA_READY clear
    pulse_sample(12'h7FF, 12'h000);
    set_tx(CMD_READ, ADDR_XDATA_L, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_txn(24, 1'b1);
    check("collide_xl", {8'd0, rx_buf[2]}, 16'h00FF);
    read_status(st);
    check("collide_status", {8'd0, st}, 16'h0001);

    check("miso_without_oe", 16'(oe_viol), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
